// File: rtl/fp_pkg.sv
// Shared constants and helpers for the FP operand pre-decode pipeline.
// Op and class bit positions, the constant 1.0 and the classifier.
package fp_pkg;

   localparam int USE_MUL  = 0;
   localparam int USE_ADD  = 1;
   localparam int NEG_PROD = 2;
   localparam int NEG_ADD  = 3;

   localparam int CLS_ZERO = 0;
   localparam int CLS_SUBN = 1;
   localparam int CLS_INF  = 2;
   localparam int CLS_QNAN = 3;
   localparam int CLS_SNAN = 4;
   localparam int CLS_W    = 5;

   // 1.0 encoded as {0, BIAS, 0}, wide enough for any caller to slice
   function automatic logic [63:0] fp_one(input int ew, input int fw);
      logic [63:0] b;
      b = (64'd1 << (ew - 1)) - 64'd1;
      return b << fw;
   endfunction

   // Class vector {snan,qnan,inf,subn,zero} from exponent/fraction summaries
   function automatic logic [CLS_W-1:0] fp_classify(
      input logic e_zero,
      input logic e_ones,
      input logic f_msb,
      input logic f_nz
   );
      logic [CLS_W-1:0] c;
      c           = '0;
      c[CLS_ZERO] = e_zero & ~f_nz;
      c[CLS_SUBN] = e_zero & f_nz;
      c[CLS_INF]  = e_ones & ~f_nz;
      c[CLS_QNAN] = e_ones & f_msb;
      c[CLS_SNAN] = e_ones & ~f_msb & f_nz;
      return c;
   endfunction

endpackage

// File: rtl/fp_unpack_pipe_lzc.sv
// Leading-zero counter used to normalise subnormal fractions.
// An all-zero input yields WIDTH.
module fp_lzc #(
   parameter int WIDTH = 23,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] data,
   output logic [CW-1:0]    count
);

   // Highest set bit wins, so scan upward and keep overwriting
   always_comb begin
      count = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (data[i]) count = CW'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fp_unpack_pipe.sv
// Two-stage multi-lane FP operand select, classify and normalise.
// S1 selects and classifies, S2 normalises subnormals.
module fp_unpack_pipe
   import fp_pkg::*;
#(
   parameter int FW    = 23,
   parameter int EW    = 8,
   parameter int LANES = 4,
   parameter int TW    = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [3:0]                     op,
   input  logic [TW-1:0]                  tag_i,
   input  logic [LANES*(EW+FW+1)-1:0]     opA,
   input  logic [LANES*(EW+FW+1)-1:0]     opB,
   input  logic [LANES*(EW+FW+1)-1:0]     opC,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [TW-1:0]                  tag_o,
   output logic [LANES*3-1:0]             sign,
   output logic [LANES*3*(EW+2)-1:0]      exponent,
   output logic [LANES*3*(FW+1)-1:0]      significant,
   output logic [LANES*3*5-1:0]           cls
);

   localparam int W  = EW + FW + 1;
   localparam int XW = EW + 2;
   localparam int N  = LANES * 3;
   localparam int LW = $clog2(FW + 1);
   localparam logic [W-1:0] ONE = W'(fp_one(EW, FW));

   logic          s1_v, s2_v, s2_adv, accept;
   logic [TW-1:0] s1_tag, s2_tag;
   logic [W-1:0]  sel    [N];
   logic [W-1:0]  s1_opnd [N];
   logic [N*CLS_W-1:0] sel_cls, s1_cls, s2_cls;
   logic [LW-1:0] lz [N];
   logic [N-1:0]      nx_sign, s2_sign;
   logic [N*XW-1:0]   nx_exp, s2_exp;
   logic [N*(FW+1)-1:0] nx_sig, s2_sig;
   logic [W-1:0]  pflip, aflip;

   assign s2_adv   = s1_v & (~s2_v | out_ready);
   assign in_ready = ~s1_v | s2_adv;
   assign accept   = in_valid & in_ready & ~flush;
   assign pflip    = {op[NEG_PROD], {(W-1){1'b0}}};
   assign aflip    = {op[NEG_ADD], {(W-1){1'b0}}};

   // Per-lane operand select with sign negation, then classify
   always_comb begin
      sel_cls = '0;
      for (int i = 0; i < LANES; i++) begin
         sel[3*i]   = '0;
         sel[3*i+1] = '0;
         sel[3*i+2] = '0;
         case ({op[USE_ADD], op[USE_MUL]})
            2'b01: begin
               sel[3*i]   = opA[i*W +: W];
               sel[3*i+1] = opB[i*W +: W] ^ pflip;
            end
            2'b10: begin
               sel[3*i]   = ONE;
               sel[3*i+1] = opA[i*W +: W];
               sel[3*i+2] = opB[i*W +: W] ^ aflip;
            end
            2'b11: begin
               sel[3*i]   = opA[i*W +: W];
               sel[3*i+1] = opB[i*W +: W] ^ pflip;
               sel[3*i+2] = opC[i*W +: W] ^ aflip;
            end
            default: ;
         endcase
      end
      for (int k = 0; k < N; k++) begin
         sel_cls[k*CLS_W +: CLS_W] = fp_classify(
            sel[k][W-2:FW] == '0,
            &sel[k][W-2:FW],
            sel[k][FW-1],
            |sel[k][FW-1:0]);
      end
   end

   // Stage valids: flush kills both, S1 refills on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else if (flush) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else begin
         if (accept)      s1_v <= 1'b1;
         else if (s2_adv) s1_v <= 1'b0;
         if (s2_adv)         s2_v <= 1'b1;
         else if (out_ready) s2_v <= 1'b0;
      end
   end

   // S1 data capture on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_tag <= '0;
         s1_cls <= '0;
         for (int k = 0; k < N; k++) s1_opnd[k] <= '0;
      end else if (accept) begin
         s1_tag <= tag_i;
         s1_cls <= sel_cls;
         for (int k = 0; k < N; k++) s1_opnd[k] <= sel[k];
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_lzc
      fp_lzc #(.WIDTH(FW)) u_lzc (
         .data  (s1_opnd[k][FW-1:0]),
         .count (lz[k])
      );
   end

   // Unpack each operand into extended exponent and leading-one significand
   always_comb begin
      for (int k = 0; k < N; k++) begin
         nx_sign[k] = s1_opnd[k][W-1];
         nx_exp[k*XW +: XW] = {2'b00, s1_opnd[k][W-2:FW]};
         nx_sig[k*(FW+1) +: FW+1] = {1'b1, s1_opnd[k][FW-1:0]};
         if (s1_cls[k*CLS_W + CLS_ZERO]) begin
            nx_exp[k*XW +: XW] = '0;
            nx_sig[k*(FW+1) +: FW+1] = '0;
         end else if (s1_cls[k*CLS_W + CLS_SUBN]) begin
            nx_exp[k*XW +: XW] = XW'(0) - XW'(lz[k]);
            nx_sig[k*(FW+1) +: FW+1] =
               (FW+1)'({s1_opnd[k][FW-1:0], 1'b0} << lz[k]);
         end
      end
   end

   // S2 output registers, loaded when S1 advances
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_tag  <= '0;
         s2_sign <= '0;
         s2_exp  <= '0;
         s2_sig  <= '0;
         s2_cls  <= '0;
      end else if (s2_adv) begin
         s2_tag  <= s1_tag;
         s2_sign <= nx_sign;
         s2_exp  <= nx_exp;
         s2_sig  <= nx_sig;
         s2_cls  <= s1_cls;
      end
   end

   assign out_valid   = s2_v;
   assign tag_o       = s2_tag;
   assign sign        = s2_sign;
   assign exponent    = s2_exp;
   assign significant = s2_sig;
   assign cls         = s2_cls;

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Directed testbench for fp_unpack_pipe (FP32, four lanes).
// Each scenario task drives vectors and checks hand-computed results.
module tb_fp_unpack_pipe;

   localparam int FW = 23, EW = 8, LANES = 4, TW = 4;
   localparam int W  = EW + FW + 1;
   localparam int XW = EW + 2;
   localparam int SW = FW + 1;

   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
   logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic [3:0] op = '0;
   logic [TW-1:0] tag_i = '0, tag_o;
   logic [LANES*W-1:0] opA = '0, opB = '0, opC = '0;
   logic [LANES*3-1:0] sign;
   logic [LANES*3*XW-1:0] exponent;
   logic [LANES*3*SW-1:0] significant;
   logic [LANES*3*5-1:0] cls;

   int checks = 0;
   int errors = 0;

   fp_unpack_pipe #(.FW(FW), .EW(EW), .LANES(LANES), .TW(TW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .tag_i(tag_i),
      .opA(opA), .opB(opB), .opC(opC),
      .out_valid(out_valid), .out_ready(out_ready),
      .tag_o(tag_o), .sign(sign), .exponent(exponent),
      .significant(significant), .cls(cls)
   );

   always #5 clk = ~clk;

   function automatic logic [XW-1:0] g_exp(int l, int j);
      return exponent[(l*3+j)*XW +: XW];
   endfunction
   function automatic logic [SW-1:0] g_sig(int l, int j);
      return significant[(l*3+j)*SW +: SW];
   endfunction
   function automatic logic [4:0] g_cls(int l, int j);
      return cls[(l*3+j)*5 +: 5];
   endfunction
   function automatic logic g_sgn(int l, int j);
      return sign[l*3+j];
   endfunction
   function automatic logic [LANES*W-1:0] rep(logic [W-1:0] x);
      return {LANES{x}};
   endfunction

   // one beat into an empty pipe; returns when it sits in S2
   task automatic beat(input logic [3:0] o, input logic [LANES*W-1:0] a,
                       input logic [LANES*W-1:0] b,
                       input logic [LANES*W-1:0] c,
                       input logic [TW-1:0] t);
      op = o; opA = a; opB = b; opC = c; tag_i = t; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL beat_in_ready got %b want 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL beat_out_valid got %b want 1", out_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || tag_o !== '0 || sign !== '0 ||
          exponent !== '0 || significant !== '0 || cls !== '0) begin
         errors++;
         $display("FAIL reset_state got v=%b tag=%h sig=%h want all 0",
                  out_valid, tag_o, significant);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_mul();
      beat(4'b0001, rep(32'h40000000), rep(32'h3F800000), '0, 4'd5);
      checks++;
      if (tag_o !== 4'd5) begin
         errors++;
         $display("FAIL mul_tag got %0d want 5", tag_o);
      end
      for (int l = 0; l < LANES; l++) begin
         checks++;
         if (g_exp(l,0) !== 10'd128 || g_sig(l,0) !== 24'h800000 ||
             g_exp(l,1) !== 10'd127 || g_cls(l,2) !== 5'b00001) begin
            errors++;
            $display("FAIL mul_lane%0d got e1=%0d s1=%h e2=%0d c3=%b want 128 800000 127 00001",
                     l, g_exp(l,0), g_sig(l,0), g_exp(l,1), g_cls(l,2));
         end
      end
   endtask

   task automatic test_add();
      beat(4'b1010, rep(32'h3F800000), rep(32'h40400000), '0, 4'd2);
      for (int l = 0; l < LANES; l++) begin
         checks++;
         if (g_exp(l,0) !== 10'd127 || g_sig(l,0) !== 24'h800000 ||
             g_exp(l,1) !== 10'd127 || g_sgn(l,2) !== 1'b1 ||
             g_exp(l,2) !== 10'd128 || g_sig(l,2) !== 24'hC00000) begin
            errors++;
            $display("FAIL add_lane%0d got e1=%0d s3=%b e3=%0d sg3=%h want 127 1 128 C00000",
                     l, g_exp(l,0), g_sgn(l,2), g_exp(l,2), g_sig(l,2));
         end
      end
   endtask

   task automatic test_subnormal();
      logic [LANES*W-1:0] b;
      b = {32'h00000001, 32'h00000001, 32'h00400000, 32'h00000001};
      beat(4'b0001, rep(32'h3F800000), b, '0, 4'd3);
      checks++;
      if (g_cls(0,1) !== 5'b00010 || g_sig(0,1) !== 24'h800000 ||
          g_exp(0,1) !== 10'h3EA) begin
         errors++;
         $display("FAIL subn_lane0 got c=%b s=%h e=%h want 00010 800000 3ea",
                  g_cls(0,1), g_sig(0,1), g_exp(0,1));
      end
      checks++;
      if (g_cls(1,1) !== 5'b00010 || g_sig(1,1) !== 24'h800000 ||
          g_exp(1,1) !== 10'h000) begin
         errors++;
         $display("FAIL subn_lane1 got c=%b s=%h e=%h want 00010 800000 000",
                  g_cls(1,1), g_sig(1,1), g_exp(1,1));
      end
   endtask

   task automatic test_special();
      beat(4'b0011, rep(32'h7FC00000), rep(32'h7F800001),
           rep(32'hFF800000), 4'd4);
      checks++;
      if (g_cls(0,0) !== 5'b01000 || g_exp(0,0) !== 10'd255 ||
          g_sig(0,0) !== 24'hC00000) begin
         errors++;
         $display("FAIL special_qnan got c=%b e=%0d s=%h want 01000 255 C00000",
                  g_cls(0,0), g_exp(0,0), g_sig(0,0));
      end
      checks++;
      if (g_cls(2,1) !== 5'b10000 || g_sig(2,1) !== 24'h800001) begin
         errors++;
         $display("FAIL special_snan got c=%b s=%h want 10000 800001",
                  g_cls(2,1), g_sig(2,1));
      end
      checks++;
      if (g_cls(3,2) !== 5'b00100 || g_sgn(3,2) !== 1'b1) begin
         errors++;
         $display("FAIL special_inf got c=%b s=%b want 00100 1",
                  g_cls(3,2), g_sgn(3,2));
      end
      beat(4'b1111, rep(32'h7FC00000), rep(32'h7F800001),
           rep(32'hFF800000), 4'd4);
      checks++;
      if (g_cls(1,2) !== 5'b00100 || g_sgn(1,2) !== 1'b0 ||
          g_sgn(1,1) !== 1'b1 || g_exp(1,2) !== 10'd255) begin
         errors++;
         $display("FAIL special_neg got c=%b s3=%b s2=%b e=%0d want 00100 0 1 255",
                  g_cls(1,2), g_sgn(1,2), g_sgn(1,1), g_exp(1,2));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int nt;
      logic [TW-1:0] got [$];
      logic acc, pop;
      logic [TW-1:0] ptag;
      nt = 1;
      op = 4'b0001; opA = rep(32'h3F800000); opB = rep(32'h3F800000);
      for (int c = 0; c < 40 && got.size() < 5; c++) begin
         out_ready = (c >= 4);
         in_valid  = (nt <= 5);
         tag_i     = TW'(nt);
         #1;
         if (c == 2 || c == 3) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp_in_ready c=%0d got %b want 0", c, in_ready);
            end
         end
         if (c == 3) begin
            checks++;
            if (out_valid !== 1'b1 || tag_o !== 4'd1) begin
               errors++;
               $display("FAIL bp_hold got v=%b tag=%0d want 1 1",
                        out_valid, tag_o);
            end
         end
         acc  = in_valid & in_ready;
         pop  = out_valid & out_ready;
         ptag = tag_o;
         @(posedge clk); #1;
         if (acc) nt++;
         if (pop) got.push_back(ptag);
      end
      in_valid = 1'b0;
      checks++;
      if (got.size() != 5) begin
         errors++;
         $display("FAIL bp_count got %0d want 5", got.size());
      end
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i] !== TW'(i + 1)) begin
            errors++;
            $display("FAIL bp_order idx=%0d got %0d want %0d",
                     i, got[i], i + 1);
         end
      end
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_flush();
      logic seen;
      out_ready = 1'b0;
      op = 4'b0001; in_valid = 1'b1;
      tag_i = 4'd7;
      @(posedge clk); #1;
      tag_i = 4'd8;
      @(posedge clk); #1;
      tag_i = 4'd9; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_state got v=%b rdy=%b want 0 1",
                  out_valid, in_ready);
      end
      out_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL flush_drop got out_valid=1 want 0");
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      beat(4'b0001, rep(32'h40000000), rep(32'h3F800000), '0, 4'd6);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || tag_o !== '0) begin
         errors++;
         $display("FAIL async_reset got v=%b tag=%0d want 0 0",
                  out_valid, tag_o);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got rdy=%b v=%b want 1 0",
                  in_ready, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_add();
      test_subnormal();
      test_special();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_unpack_pipe.md
Name: fp_unpack_pipe

Overview:
- Pipelined, multi-lane FP operand pre-decode stage feeding the vector FMA datapath.
- Per lane: selects multiplier/adder operands from the op code, applies sign negations and classifies each operand. Classes: zero, subnormal, inf, qNaN, sNaN.
- Normalises subnormal significands, so downstream multiply/add stages see a leading-one significand with an extended signed exponent.
- Elastic valid/ready interface with flush; replaces the single-lane combinational pre-decoder.

Parameters:
- FW, 23, fraction width.
- EW, 8, exponent width.
- LANES, 4, independent lanes processed in lockstep.
- TW, 4, sideband tag width, passed through unchanged.
- Derived: W = EW+FW+1; XW = EW+2, signed extended exponent width; BIAS = 2**(EW-1)-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- op  in  4  {neg_addend, neg_product, use_add, use_mul}.
- tag_i  in  TW  sideband.
- opA, opB, opC  in  LANES*W each  packed lane operands; lane i at [i*W +: W].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- tag_o  out  TW  sideband.
- sign  out  LANES*3  per lane {s3,s2,s1}.
- exponent  out  LANES*3*XW  signed extended exponents.
- significant  out  LANES*3*(FW+1)  significands.
- cls  out  LANES*3*5  per operand {snan,qnan,inf,subn,zero}.

Behaviour:
- Reset (rst_n low, async): out_valid=0, both stage valids 0, all data/tag registers 0. in_ready=1 once reset is released.
- Operand select per lane, from op[1:0]:
  - 01: op1=A, op2=B^neg_product (sign flip), op3=+0.
  - 10: op1=1.0 encoded {0,BIAS,0}, op2=A, op3=B^neg_addend.
  - 11: op1=A, op2=B^neg_product, op3=C^neg_addend.
  - 00: all three = +0.
- Stage S1 (on accept):
  - Registers selected operands, op and tag.
  - Computes classes:
    - zero: exponent 0 and fraction 0.
    - subn: exponent 0 and fraction nonzero.
    - inf: exponent all-ones and fraction 0.
    - qnan: exponent all-ones and fraction MSB 1.
    - sNaN: exponent all-ones, fraction MSB 0, fraction nonzero.
- Stage S2 (on advance), per operand:
  - Normal: exp = biased exponent (zero-extended), sig = {1,frac}.
  - Subnormal: lz = leading zeros of frac; sig = {frac,0} << lz, so MSB=1; exp = -lz (signed; true value 1-BIAS-(lz+1)+BIAS... encoded as biased 1-(lz+1)).
  - Zero: exp=0, sig=0.
  - Inf/NaN: exp = 2**EW-1, sig = {1,frac}.
  - Sign passes through unchanged, including for zero and NaN.
- Latency: 2 cycles from accept to out_valid when there is no stall. Throughput: 1 beat/cycle.
- Handshake:
  - A beat transfers on in_valid&in_ready, and on out_valid&out_ready.
  - s2_adv = s1_v & (~s2_v | out_ready).
  - in_ready = ~s1_v | s2_adv.
  - ready is combinational from out_ready; no combinational in_valid->out path.
  - Outputs hold stable while out_valid & ~out_ready.
- Full pipeline with out_ready=0: in_ready=0 and no beat is lost.
- Simultaneous pop at S2 and push at S1: both occur in the same cycle; order is preserved.
- flush:
  - Next edge clears s1_v and s2_v.
  - An input presented in the flush cycle is dropped, even if in_ready=1.
  - Data registers are not cleared.
- Lanes are fully independent in datapath; they share a single valid/tag.

Decomposition:
- fp_pkg holds:
  - op bit index constants (USE_MUL=0, USE_ADD=1, NEG_PROD=2, NEG_ADD=3).
  - class bit index constants.
  - Function fp_one(EW,FW).
  - Function fp_classify returning a 5-bit class.
- Sub-module fp_lzc #(WIDTH): combinational leading-zero count, output width $clog2(WIDTH+1). Instantiated LANES*3 times in S2.

Test Plan (FP32, LANES=4 unless noted):
1. op=0001, A=0x40000000, B=0x3F800000, all lanes, tag=5 -> out_valid 2 cycles later, tag_o=5.
   - op1: exp=128, sig=0x800000.
   - op2: exp=127.
   - op3: cls=zero.
2. op=1010, A=0x3F800000, B=0x40400000 -> op1 exp=127, sig=0x800000; op3 s=1, exp=128, sig=0xC00000.
3. op=0001, B=0x00000001 lane0, B=0x00400000 lane1 (both subnormal):
   - lane0: cls=subn, sig=0x800000, exp=-22.
   - lane1: sig=0x800000, exp=0.
4. op=0011, A=0x7FC00000, B=0x7F800001, C=0xFF800000 (op=1111 for C) ->
   - A: qnan.
   - B: snan.
   - C: inf with s3=0 (sign flipped by neg_addend).
5. Backpressure: 5 back-to-back beats, tags 1..5, out_ready=0 for 4 cycles then 1 ->
   - in_ready drops after 2 accepted beats.
   - Tags emerge 1..5 in order, none lost or duplicated.
6. Both stages full, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed beat never appears. Separately, rst_n=0 mid-stream -> out_valid=0 immediately, tag_o=0.
